tt_lq_ooo: RTL and testbench

- Parametrised in-order-retire load queue.
- Tracks outstanding memory loads (scalar, FP, vector) from allocation at the memory stage through out-of-order response return to in-order writeback.
- Successor to the fixed-depth, scalar-info load queue: depth, data width and info width are generic; adds no-data entries, flush and response-error reporting.
- Sits between the memory skid buffer (allocation) and the register-file writeback arbiter (retire).

---
 rtl/tt_lq_ooo.sv | 123 ++++++++++++
 tb/tb_tt_lq_ooo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_lq_ooo.sv
// In-order-retire load queue: entries allocate at the tail, complete out of order
// through responses, and retire from the head strictly in allocation order.
module tt_lq_ooo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 256,
    parameter int INFO_W = 40,
    parameter int ID_W   = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_alloc_vld,
    input  logic              i_alloc_nodata,
    input  logic [INFO_W-1:0] i_alloc_info,
    output logic              o_alloc_rdy,
    output logic [ID_W-1:0]   o_alloc_id,
    input  logic              i_resp_vld,
    input  logic [ID_W-1:0]   i_resp_id,
    input  logic [DATA_W-1:0] i_resp_data,
    output logic              o_resp_err,
    output logic              o_ret_vld,
    input  logic              i_ret_rdy,
    output logic [ID_W-1:0]   o_ret_id,
    output logic [INFO_W-1:0] o_ret_info,
    output logic [DATA_W-1:0] o_ret_data,
    output logic              o_ret_nodata,
    input  logic              i_flush,
    output logic [ID_W:0]     o_count,
    output logic              o_empty
);

    localparam logic [ID_W:0] PTR_ONE = (ID_W+1)'(1);

    // Pointers carry an extra wrap bit above the index to tell full from empty.
    logic [ID_W:0]       head_q, tail_q, count_q;
    logic [DEPTH-1:0]    valid_q, done_q, nodata_q;
    logic [INFO_W-1:0]   info_mem [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic                resp_err_q;

    logic [ID_W-1:0]     head_idx, tail_idx;
    logic                full, alloc_fire, ret_fire, resp_ok;

    assign head_idx = head_q[ID_W-1:0];
    assign tail_idx = tail_q[ID_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[ID_W] != tail_q[ID_W]);

    // Handshakes: a transfer happens on a cycle where valid and ready are both high.
    // Ready is derived from registered state only, and valid never looks at ready,
    // so a stalled retire presents the same head until it is accepted.
    assign o_alloc_rdy = !full;
    assign alloc_fire  = i_alloc_vld && o_alloc_rdy;
    assign o_ret_vld   = valid_q[head_idx] && done_q[head_idx];
    assign ret_fire    = o_ret_vld && i_ret_rdy;

    // The tail entry is invalid whenever an alloc can fire, but the explicit
    // compare keeps a same-cycle response to the new id an error regardless.
    assign resp_ok = i_resp_vld && valid_q[i_resp_id] && !done_q[i_resp_id]
                     && !(alloc_fire && (i_resp_id == tail_idx));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            valid_q    <= '0;
            done_q     <= '0;
            nodata_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            resp_err_q <= 1'b0;
        end else if (i_flush) begin
            valid_q    <= '0;
            done_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            resp_err_q <= i_resp_vld && !resp_ok;
            if (alloc_fire) begin
                valid_q[tail_idx]  <= 1'b1;
                done_q[tail_idx]   <= i_alloc_nodata;
                nodata_q[tail_idx] <= i_alloc_nodata;
                tail_q             <= tail_q + PTR_ONE;
            end
            if (resp_ok) begin
                done_q[i_resp_id] <= 1'b1;
            end
            // Head is done and tail is invalid, so neither can collide with resp_ok.
            if (ret_fire) begin
                valid_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
                head_q            <= head_q + PTR_ONE;
            end
            case ({alloc_fire, ret_fire})
                2'b10:   count_q <= count_q + PTR_ONE;
                2'b01:   count_q <= count_q - PTR_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage has no reset; zeroing data at allocation gives nodata entries 0.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && !i_flush) begin
            if (alloc_fire) begin
                info_mem[tail_idx] <= i_alloc_info;
                data_mem[tail_idx] <= '0;
            end
            if (resp_ok) begin
                data_mem[i_resp_id] <= i_resp_data;
            end
        end
    end

    assign o_alloc_id   = tail_idx;
    assign o_resp_err   = resp_err_q;
    assign o_ret_id     = head_idx;
    assign o_ret_info   = info_mem[head_idx];
    assign o_ret_data   = data_mem[head_idx];
    assign o_ret_nodata = nodata_q[head_idx];
    assign o_count      = count_q;
    assign o_empty      = (count_q == '0);

endmodule

// File: tb/tb_tt_lq_ooo.sv
// Directed bench for tt_lq_ooo: ordering, full/wrap, nodata, response errors,
// flush, reset and a back-to-back stream.
module tb_tt_lq_ooo;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 256;
    localparam int INFO_W = 40;
    localparam int ID_W   = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              alloc_vld = 1'b0, alloc_nodata = 1'b0;
    logic [INFO_W-1:0] alloc_info = '0;
    logic              alloc_rdy;
    logic [ID_W-1:0]   alloc_id;
    logic              resp_vld = 1'b0;
    logic [ID_W-1:0]   resp_id = '0;
    logic [DATA_W-1:0] resp_data = '0;
    logic              resp_err;
    logic              ret_vld;
    logic              ret_rdy = 1'b0;
    logic [ID_W-1:0]   ret_id;
    logic [INFO_W-1:0] ret_info;
    logic [DATA_W-1:0] ret_data;
    logic              ret_nodata;
    logic              flush = 1'b0;
    logic [ID_W:0]     count;
    logic              empty;

    int checks = 0;
    int failures = 0;
    logic [DATA_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    tt_lq_ooo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .INFO_W(INFO_W)) dut (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_alloc_vld(alloc_vld), .i_alloc_nodata(alloc_nodata), .i_alloc_info(alloc_info),
        .o_alloc_rdy(alloc_rdy), .o_alloc_id(alloc_id),
        .i_resp_vld(resp_vld), .i_resp_id(resp_id), .i_resp_data(resp_data),
        .o_resp_err(resp_err),
        .o_ret_vld(ret_vld), .i_ret_rdy(ret_rdy), .o_ret_id(ret_id),
        .o_ret_info(ret_info), .o_ret_data(ret_data), .o_ret_nodata(ret_nodata),
        .i_flush(flush), .o_count(count), .o_empty(empty)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; alloc_vld = 1'b0; resp_vld = 1'b0; ret_rdy = 1'b0; flush = 1'b0;
        alloc_nodata = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (alloc_rdy !== 1'b1) begin failures++; $display("FAIL reset_alloc_rdy got=%0b exp=1", alloc_rdy); end
        checks++; if (ret_vld !== 1'b0) begin failures++; $display("FAIL reset_ret_vld got=%0b exp=0", ret_vld); end
        checks++; if (empty !== 1'b1 || count !== 4'd0) begin failures++; $display("FAIL reset_empty got=%0b/%0d exp=1/0", empty, count); end
        checks++; if (alloc_id !== 3'd0 || ret_id !== 3'd0) begin failures++; $display("FAIL reset_ids got=%0d/%0d exp=0/0", alloc_id, ret_id); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err got=%0b exp=0", resp_err); end
    endtask

    task automatic test_in_order();
        logic [INFO_W-1:0] infos [3];
        infos[0] = 40'hA; infos[1] = 40'hB; infos[2] = 40'hC;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc_vld = 1'b1; alloc_info = infos[i];
            checks++; if (alloc_id !== 3'(i)) begin failures++; $display("FAIL order_alloc_id got=%0d exp=%0d", alloc_id, i); end
            step();
        end
        alloc_vld = 1'b0;
        checks++; if (count !== 4'd3 || ret_vld !== 1'b0) begin failures++; $display("FAIL order_count got=%0d/%0b exp=3/0", count, ret_vld); end
        resp_vld = 1'b1; resp_id = 3'd2; resp_data = DATA_W'(8'h22);
        step();
        checks++; if (ret_vld !== 1'b0) begin failures++; $display("FAIL order_wait_head got=%0b exp=0", ret_vld); end
        resp_id = 3'd0; resp_data = DATA_W'(8'h00);
        step();
        checks++; if (ret_vld !== 1'b1 || ret_id !== 3'd0 || ret_data !== DATA_W'(8'h00) || ret_info !== 40'hA) begin
            failures++; $display("FAIL order_ret0 got=%0b/%0d/%0h/%0h exp=1/0/0/a", ret_vld, ret_id, ret_data, ret_info); end
        resp_id = 3'd1; resp_data = DATA_W'(8'h11); ret_rdy = 1'b1;
        step();
        resp_vld = 1'b0;
        checks++; if (ret_vld !== 1'b1 || ret_id !== 3'd1 || ret_data !== DATA_W'(8'h11) || ret_info !== 40'hB) begin
            failures++; $display("FAIL order_ret1 got=%0b/%0d/%0h/%0h exp=1/1/11/b", ret_vld, ret_id, ret_data, ret_info); end
        step();
        checks++; if (ret_vld !== 1'b1 || ret_id !== 3'd2 || ret_data !== DATA_W'(8'h22) || ret_info !== 40'hC) begin
            failures++; $display("FAIL order_ret2 got=%0b/%0d/%0h/%0h exp=1/2/22/c", ret_vld, ret_id, ret_data, ret_info); end
        step();
        ret_rdy = 1'b0;
        checks++; if (empty !== 1'b1 || ret_vld !== 1'b0) begin failures++; $display("FAIL order_drained got=%0b/%0b exp=1/0", empty, ret_vld); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            alloc_vld = 1'b1; alloc_info = INFO_W'(i);
            step();
        end
        alloc_vld = 1'b0;
        checks++; if (alloc_rdy !== 1'b0 || count !== 4'd8) begin failures++; $display("FAIL full_state got=%0b/%0d exp=0/8", alloc_rdy, count); end
        resp_vld = 1'b1; resp_id = 3'd0; resp_data = DATA_W'(8'h5A);
        step();
        resp_vld = 1'b0;
        ret_rdy = 1'b1; alloc_vld = 1'b1; alloc_info = 40'h99;
        step();
        ret_rdy = 1'b0; alloc_vld = 1'b0;
        checks++; if (count !== 4'd7 || alloc_rdy !== 1'b1) begin failures++; $display("FAIL full_alloc_blocked got=%0d/%0b exp=7/1", count, alloc_rdy); end
        checks++; if (ret_id !== 3'd1 || ret_vld !== 1'b0 || alloc_id !== 3'd0) begin
            failures++; $display("FAIL full_wrap_ids got=%0d/%0b/%0d exp=1/0/0", ret_id, ret_vld, alloc_id); end
        alloc_vld = 1'b1;
        step();
        alloc_vld = 1'b0;
        checks++; if (count !== 4'd8 || alloc_rdy !== 1'b0) begin failures++; $display("FAIL full_refill got=%0d/%0b exp=8/0", count, alloc_rdy); end
    endtask

    task automatic test_nodata();
        do_reset();
        alloc_vld = 1'b1; alloc_nodata = 1'b1; alloc_info = 40'h1;
        step();
        alloc_nodata = 1'b0; alloc_info = 40'h2; ret_rdy = 1'b1;
        checks++; if (ret_vld !== 1'b1 || ret_nodata !== 1'b1 || ret_data !== '0 || ret_id !== 3'd0) begin
            failures++; $display("FAIL nodata_head got=%0b/%0b/%0h/%0d exp=1/1/0/0", ret_vld, ret_nodata, ret_data, ret_id); end
        step();
        alloc_vld = 1'b0;
        checks++; if (ret_vld !== 1'b0 || ret_id !== 3'd1 || count !== 4'd1) begin
            failures++; $display("FAIL nodata_load_waits got=%0b/%0d/%0d exp=0/1/1", ret_vld, ret_id, count); end
        step();
        ret_rdy = 1'b0;
        checks++; if (ret_vld !== 1'b0 || count !== 4'd1) begin failures++; $display("FAIL nodata_still_waits got=%0b/%0d exp=0/1", ret_vld, count); end
    endtask

    task automatic test_resp_err();
        do_reset();
        resp_vld = 1'b1; resp_id = 3'd5; resp_data = DATA_W'(8'hEE);
        step();
        resp_vld = 1'b0;
        checks++; if (resp_err !== 1'b1 || count !== 4'd0) begin failures++; $display("FAIL err_empty got=%0b/%0d exp=1/0", resp_err, count); end
        step();
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL err_pulse_len got=%0b exp=0", resp_err); end
        alloc_vld = 1'b1; step(); step(); alloc_vld = 1'b0;
        resp_vld = 1'b1; resp_id = 3'd1; resp_data = DATA_W'(8'h77);
        step();
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL err_good_resp got=%0b exp=0", resp_err); end
        resp_data = DATA_W'(8'h88);
        step();
        resp_vld = 1'b0;
        checks++; if (resp_err !== 1'b1 || count !== 4'd2 || ret_vld !== 1'b0) begin
            failures++; $display("FAIL err_done_resp got=%0b/%0d/%0b exp=1/2/0", resp_err, count, ret_vld); end
        step();
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL err_pulse_len2 got=%0b exp=0", resp_err); end
        alloc_vld = 1'b1; resp_vld = 1'b1; resp_id = 3'd2;
        step();
        alloc_vld = 1'b0;
        checks++; if (resp_err !== 1'b1 || count !== 4'd3) begin failures++; $display("FAIL err_same_cycle_alloc got=%0b/%0d exp=1/3", resp_err, count); end
        resp_id = 3'd0; resp_data = DATA_W'(8'h03);
        step();
        resp_vld = 1'b0;
        checks++; if (ret_vld !== 1'b1 || ret_id !== 3'd0 || ret_data !== DATA_W'(8'h03)) begin
            failures++; $display("FAIL err_head_ok got=%0b/%0d/%0h exp=1/0/3", ret_vld, ret_id, ret_data); end
        ret_rdy = 1'b1;
        step();
        ret_rdy = 1'b0;
        checks++; if (ret_vld !== 1'b1 || ret_id !== 3'd1 || ret_data !== DATA_W'(8'h77)) begin
            failures++; $display("FAIL err_data_kept got=%0b/%0d/%0h exp=1/1/77", ret_vld, ret_id, ret_data); end
    endtask

    task automatic test_flush_reset();
        do_reset();
        alloc_vld = 1'b1;
        for (int i = 0; i < 4; i++) step();
        flush = 1'b1; resp_vld = 1'b1; resp_id = 3'd1;
        step();
        flush = 1'b0; resp_vld = 1'b0; alloc_vld = 1'b0;
        checks++; if (count !== 4'd0 || empty !== 1'b1 || resp_err !== 1'b0) begin
            failures++; $display("FAIL flush_state got=%0d/%0b/%0b exp=0/1/0", count, empty, resp_err); end
        checks++; if (alloc_id !== 3'd0 || ret_vld !== 1'b0 || alloc_rdy !== 1'b1) begin
            failures++; $display("FAIL flush_ptrs got=%0d/%0b/%0b exp=0/0/1", alloc_id, ret_vld, alloc_rdy); end
        resp_vld = 1'b1;
        step();
        resp_vld = 1'b0;
        checks++; if (resp_err !== 1'b1) begin failures++; $display("FAIL flush_stale_resp got=%0b exp=1", resp_err); end
        alloc_vld = 1'b1;
        step();
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL flush_realloc got=%0d exp=1", count); end
        resp_vld = 1'b1; resp_id = 3'd0;
        step(); step();
        resp_id = 3'd1; reset_n = 1'b0;
        step();
        reset_n = 1'b1; alloc_vld = 1'b0; resp_vld = 1'b0;
        checks++; if (count !== 4'd0 || empty !== 1'b1 || resp_err !== 1'b0 || alloc_id !== 3'd0 || ret_vld !== 1'b0) begin
            failures++; $display("FAIL midreset_state got=%0d/%0b/%0b/%0d/%0b exp=0/1/0/0/0", count, empty, resp_err, alloc_id, ret_vld); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ret_rdy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            alloc_vld = (k < 10); alloc_info = INFO_W'(k);
            resp_vld = (k >= 1 && k <= 10);
            resp_id = 3'((k - 1) % DEPTH);
            resp_data = DATA_W'(32'h100 + k - 1);
            if (resp_vld) exp_q.push_back(resp_data);
            step();
            if (ret_vld) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_extra_retire got=%0h exp=none", ret_data); end
                else if (ret_data !== exp_q[0]) begin failures++; $display("FAIL b2b_data got=%0h exp=%0h", ret_data, exp_q[0]); void'(exp_q.pop_front()); end
                else void'(exp_q.pop_front());
            end
        end
        alloc_vld = 1'b0; resp_vld = 1'b0;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
            step();
            if (ret_vld) begin
                checks++;
                if (ret_data !== exp_q[0]) begin failures++; $display("FAIL b2b_drain_data got=%0h exp=%0h", ret_data, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
        step();
        ret_rdy = 1'b0;
        checks++; if (exp_q.size() != 0 || empty !== 1'b1) begin
            failures++; $display("FAIL b2b_drain_timeout got=%0d/%0b exp=0/1", exp_q.size(), empty); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_nodata();
        test_resp_err();
        test_flush_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
